// File: rtl/memory_grid_renderer.sv
// Memory-card game board: game state FSM plus per-pixel colour for the 640x480 raster.
// Buttons pass through an edge register, and pixel colour is registered once.
module memory_grid_renderer #(
    parameter int COLS        = 5,
    parameter int ROWS        = 4,
    parameter int X0          = 20,
    parameter int Y0          = 20,
    parameter int CARD_W      = 104,
    parameter int CARD_H      = 95,
    parameter int GAP         = 20,
    parameter int BORDER      = 4,
    parameter int SHOW_FRAMES = 60
) (
    input  logic                                  clock_25M,
    input  logic                                  reset_n,
    input  logic [9:0]                            sx,
    input  logic [9:0]                            sy,
    input  logic                                  de,
    input  logic                                  frame,
    input  logic                                  select,
    input  logic                                  move_x,
    input  logic                                  move_y,
    output logic [9:0]                            vga_r,
    output logic [9:0]                            vga_g,
    output logic [9:0]                            vga_b,
    output logic                                  win,
    output logic [$clog2(COLS*ROWS/2+1)-1:0]      matched_count
);
    localparam int N       = COLS * ROWS;
    localparam int PAIRS   = N / 2;
    localparam int KW      = (N > 1) ? $clog2(N) : 1;
    localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PITCH_X = CARD_W + GAP;
    localparam int PITCH_Y = CARD_H + GAP;

    typedef enum logic [1:0] {IDLE, ONE_UP, REVEAL, WON} state_t;

    function automatic logic [29:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    return {10'd0,    10'd1023, 10'd1023};
            3'd1:    return {10'd1023, 10'd1023, 10'd0};
            3'd2:    return {10'd1023, 10'd0,    10'd1023};
            3'd3:    return {10'd1023, 10'd0,    10'd0};
            3'd4:    return {10'd0,    10'd1023, 10'd0};
            3'd5:    return {10'd0,    10'd0,    10'd1023};
            3'd6:    return {10'd1023, 10'd512,  10'd0};
            default: return {10'd512,  10'd512,  10'd512};
        endcase
    endfunction

    function automatic logic [29:0] dim(input logic [29:0] c);
        return {1'b0, c[29:21], 1'b0, c[19:11], 1'b0, c[9:1]};
    endfunction

    function automatic logic [2:0] pal_idx(input logic [KW-1:0] k);
        int p;
        p = (int'(k) % PAIRS) % 8;
        return 3'(p);
    endfunction

    state_t          state_q, state_d;
    logic [N-1:0]    up_q, matched_q;
    logic [CW-1:0]   cur_col_q;
    logic [RW-1:0]   cur_row_q;
    logic [KW-1:0]   first_q, second_q, cur_card;
    logic [7:0]      cnt_q;
    logic            sel_prev_q, mx_prev_q, my_prev_q;
    logic            sel_edge_p0, mx_edge_p0, my_edge_p0;
    logic            card_free, pair_hit;
    logic            take_first, take_second, resolve, clear_all;

    // p0: button edge register; previous levels reset high so held buttons never fire
    always_ff @(posedge clock_25M) begin
        if (!reset_n) begin
            sel_prev_q  <= 1'b1;
            mx_prev_q   <= 1'b1;
            my_prev_q   <= 1'b1;
            sel_edge_p0 <= 1'b0;
            mx_edge_p0  <= 1'b0;
            my_edge_p0  <= 1'b0;
        end else begin
            sel_prev_q  <= select;
            mx_prev_q   <= move_x;
            my_prev_q   <= move_y;
            sel_edge_p0 <= select & ~sel_prev_q;
            mx_edge_p0  <= move_x & ~mx_prev_q;
            my_edge_p0  <= move_y & ~my_prev_q;
        end
    end

    always_comb begin
        cur_card    = KW'(int'(cur_row_q) * COLS + int'(cur_col_q));
        card_free   = !up_q[cur_card] && !matched_q[cur_card];
        pair_hit    = (int'(first_q) % PAIRS) == (int'(second_q) % PAIRS);
        state_d     = state_q;
        take_first  = 1'b0;
        take_second = 1'b0;
        resolve     = 1'b0;
        clear_all   = 1'b0;
        unique case (state_q)
            IDLE: if (sel_edge_p0 && card_free) begin
                take_first = 1'b1;
                state_d    = ONE_UP;
            end
            ONE_UP: if (sel_edge_p0 && card_free && cur_card != first_q) begin
                take_second = 1'b1;
                state_d     = REVEAL;
            end
            REVEAL: if (frame && cnt_q == 8'(SHOW_FRAMES - 1)) begin
                resolve = 1'b1;
                state_d = (pair_hit && int'(matched_count) + 1 == PAIRS) ? WON : IDLE;
            end
            WON: if (sel_edge_p0) begin
                clear_all = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // p1: game state; the select uses the cursor as it was before any coincident move
    always_ff @(posedge clock_25M) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            up_q          <= '0;
            matched_q     <= '0;
            cur_col_q     <= '0;
            cur_row_q     <= '0;
            first_q       <= '0;
            second_q      <= '0;
            cnt_q         <= '0;
            matched_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != REVEAL) begin
                if (mx_edge_p0)
                    cur_col_q <= (cur_col_q == CW'(COLS - 1)) ? '0 : cur_col_q + 1'b1;
                if (my_edge_p0)
                    cur_row_q <= (cur_row_q == RW'(ROWS - 1)) ? '0 : cur_row_q + 1'b1;
            end
            if (state_q == REVEAL && frame)
                cnt_q <= cnt_q + 1'b1;
            if (take_first) begin
                up_q[cur_card] <= 1'b1;
                first_q        <= cur_card;
            end
            if (take_second) begin
                up_q[cur_card] <= 1'b1;
                second_q       <= cur_card;
                cnt_q          <= '0;
            end
            if (resolve) begin
                up_q[first_q]  <= 1'b0;
                up_q[second_q] <= 1'b0;
                if (pair_hit) begin
                    matched_q[first_q]  <= 1'b1;
                    matched_q[second_q] <= 1'b1;
                    matched_count       <= matched_count + 1'b1;
                end
            end
            if (clear_all) begin
                up_q          <= '0;
                matched_q     <= '0;
                matched_count <= '0;
                cur_col_q     <= '0;
                cur_row_q     <= '0;
            end
        end
    end

    assign win = (state_q == WON);

    int            col_i, row_i, lx, ly;
    logic          hit_x, hit_y, on_border;
    logic [KW-1:0] pix_card;
    logic [29:0]   pal, colour;

    always_comb begin
        hit_x = 1'b0;
        hit_y = 1'b0;
        col_i = 0;
        row_i = 0;
        lx    = 0;
        ly    = 0;
        for (int c = 0; c < COLS; c++) begin
            if (int'(sx) >= X0 + c * PITCH_X && int'(sx) < X0 + c * PITCH_X + CARD_W) begin
                hit_x = 1'b1;
                col_i = c;
                lx    = int'(sx) - (X0 + c * PITCH_X);
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            if (int'(sy) >= Y0 + r * PITCH_Y && int'(sy) < Y0 + r * PITCH_Y + CARD_H) begin
                hit_y = 1'b1;
                row_i = r;
                ly    = int'(sy) - (Y0 + r * PITCH_Y);
            end
        end
        pix_card  = KW'(row_i * COLS + col_i);
        pal       = palette(pal_idx(pix_card));
        on_border = (lx < BORDER) || (lx >= CARD_W - BORDER) ||
                    (ly < BORDER) || (ly >= CARD_H - BORDER);
        colour    = '0;
        if (de && hit_x && hit_y) begin
            if (pix_card == cur_card && on_border)
                colour = '0;
            else if (matched_q[pix_card] && state_q != WON)
                colour = dim(pal);
            else if (up_q[pix_card] || state_q == WON)
                colour = pal;
            else
                colour = {10'd1023, 10'd1023, 10'd1023};
        end
    end

    // p2: registered colour out
    always_ff @(posedge clock_25M) begin
        if (!reset_n) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else begin
            vga_r <= colour[29:20];
            vga_g <= colour[19:10];
            vga_b <= colour[9:0];
        end
    end
endmodule

// File: tb/tb_memory_grid_renderer.sv
// Scenario bench for memory_grid_renderer: tasks push expectations, a negedge monitor pops and compares.
module tb_memory_grid_renderer;
    logic       clk = 1'b0;
    logic       reset_n, de, frame, select, move_x, move_y;
    logic [9:0] sx, sy, vga_r, vga_g, vga_b;
    logic       win;
    logic [3:0] matched_count;

    memory_grid_renderer dut (
        .clock_25M(clk), .reset_n(reset_n), .sx(sx), .sy(sy), .de(de), .frame(frame),
        .select(select), .move_x(move_x), .move_y(move_y),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .win(win), .matched_count(matched_count)
    );

    always #20 clk = ~clk;

    typedef struct {
        int          due;
        int          kind;
        logic [29:0] val;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic done = 1'b0;
    int   tc_col = 0;
    int   tc_row = 0;

    localparam logic [29:0] WHITE = {10'd1023, 10'd1023, 10'd1023};
    localparam logic [29:0] BLACK = 30'd0;

    function automatic logic [29:0] pal(input int k);
        case ((k % 10) % 8)
            0:       return {10'd0,    10'd1023, 10'd1023};
            1:       return {10'd1023, 10'd1023, 10'd0};
            2:       return {10'd1023, 10'd0,    10'd1023};
            3:       return {10'd1023, 10'd0,    10'd0};
            4:       return {10'd0,    10'd1023, 10'd0};
            5:       return {10'd0,    10'd0,    10'd1023};
            6:       return {10'd1023, 10'd512,  10'd0};
            default: return {10'd512,  10'd512,  10'd512};
        endcase
    endfunction

    function automatic int cx(input int k);
        return 20 + (k % 5) * 124 + 50;
    endfunction

    function automatic int cy(input int k);
        return 20 + (k / 5) * 115 + 45;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t        e;
        logic [29:0] act;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            case (e.kind)
                0:       act = {vga_r, vga_g, vga_b};
                1:       act = {29'd0, win};
                default: act = {26'd0, matched_count};
            endcase
            total++;
            if (e.due != cyc || act !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h (cycle %0d, due %0d)", e.name, act, e.val, cyc, e.due);
            end
        end
        if (done) begin
            total++;
            if (sb_q.size() != 0) begin
                bad++;
                $display("FAIL drain: got %0d pending want 0", sb_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic probe(input string nm, input int x, input int y, input logic d, input logic [29:0] ex);
        @(posedge clk); #1;
        sx = 10'(x);
        sy = 10'(y);
        de = d;
        sb_q.push_back('{cyc + 1, 0, ex, nm});
    endtask

    task automatic status(input string nm, input logic w, input int mc);
        @(posedge clk); #1;
        sb_q.push_back('{cyc, 1, {29'd0, w}, {nm, ".win"}});
        sb_q.push_back('{cyc, 2, 30'(mc), {nm, ".count"}});
    endtask

    task automatic press(input logic s, input logic mx, input logic my);
        @(posedge clk); #1;
        select = s;
        move_x = mx;
        move_y = my;
        @(posedge clk); #1;
        select = 1'b0;
        move_x = 1'b0;
        move_y = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 frame = 1'b1;
            @(posedge clk); #1 frame = 1'b0;
        end
    endtask

    task automatic goto_card(input int k);
        while (tc_col != k % 5) begin
            press(1'b0, 1'b1, 1'b0);
            tc_col = (tc_col + 1) % 5;
        end
        while (tc_row != k / 5) begin
            press(1'b0, 1'b0, 1'b1);
            tc_row = (tc_row + 1) % 4;
        end
    endtask

    task automatic pick(input int k);
        goto_card(k);
        press(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tc_col = 0;
        tc_row = 0;
    endtask

    task automatic test_reset();
        probe("rst_pixel", 150, 60, 1'b1, BLACK);
        status("rst_state", 1'b0, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        probe("card1_down", 150, 60, 1'b1, WHITE);
        probe("de_low", 150, 60, 1'b0, BLACK);
        probe("cursor_border0", 22, 60, 1'b1, BLACK);
        probe("card0_down", 60, 60, 1'b1, WHITE);
        probe("outside", 10, 10, 1'b1, BLACK);
        probe("gap", 130, 60, 1'b1, BLACK);
    endtask

    task automatic test_cursor();
        for (int i = 0; i < 5; i++) press(1'b0, 1'b1, 1'b0);
        probe("wrap_border0", 22, 60, 1'b1, BLACK);
        probe("wrap_card1_edge", 146, 60, 1'b1, WHITE);
        press(1'b0, 1'b1, 1'b1);
        tc_col = 1;
        tc_row = 1;
        probe("diag_border6", 146, 137, 1'b1, BLACK);
        probe("diag_card6_in", cx(6), cy(6), 1'b1, WHITE);
        probe("diag_card0_edge", 22, 60, 1'b1, WHITE);
    endtask

    task automatic test_mismatch();
        do_reset();
        pick(0);
        pick(1);
        probe("mm_card0_up", 60, 60, 1'b1, pal(0));
        probe("mm_card1_up", cx(1), cy(1), 1'b1, pal(1));
        press(1'b1, 1'b0, 1'b0);
        frames(59);
        probe("mm_card0_59", 60, 60, 1'b1, pal(0));
        frames(1);
        probe("mm_card0_down", 60, 60, 1'b1, WHITE);
        probe("mm_card1_down", cx(1), cy(1), 1'b1, WHITE);
        status("mm_state", 1'b0, 0);
    endtask

    task automatic test_match();
        pick(0);
        goto_card(10);
        pick(10);
        probe("m_card10_up", cx(10), cy(10), 1'b1, pal(0));
        frames(59);
        status("m_59", 1'b0, 0);
        frames(1);
        status("m_60", 1'b0, 1);
        probe("m_card0_dim", 60, 60, 1'b1, {10'd0, 10'd511, 10'd511});
        probe("m_card10_dim", cx(10), cy(10), 1'b1, {10'd0, 10'd511, 10'd511});
    endtask

    task automatic test_win();
        for (int p = 1; p < 10; p++) begin
            pick(p);
            pick(p + 10);
            frames(60);
        end
        status("won", 1'b1, 10);
        probe("won_card3", cx(3), cy(3), 1'b1, pal(3));
        probe("won_card16", cx(16), cy(16), 1'b1, pal(16));
        probe("won_card17", cx(17), cy(17), 1'b1, pal(17));
        probe("won_card0", 60, 60, 1'b1, pal(0));
        probe("won_card19", cx(19), cy(19), 1'b1, pal(19));
        press(1'b1, 1'b0, 1'b0);
        tc_col = 0;
        tc_row = 0;
        status("restart", 1'b0, 0);
        probe("restart_border0", 22, 60, 1'b1, BLACK);
        probe("restart_card3", cx(3), cy(3), 1'b1, WHITE);
        probe("restart_card0", 60, 60, 1'b1, WHITE);
    endtask

    task automatic test_reset_mid_reveal();
        pick(0);
        goto_card(10);
        pick(10);
        frames(30);
        @(posedge clk); #1;
        reset_n = 1'b0;
        select  = 1'b1;
        sx = 10'd60;
        sy = 10'd60;
        de = 1'b1;
        sb_q.push_back('{cyc + 1, 0, BLACK, "mid_rst_pixel"});
        @(posedge clk); #1;
        reset_n = 1'b1;
        sb_q.push_back('{cyc, 1, 30'd0, "mid_rst.win"});
        sb_q.push_back('{cyc, 2, 30'd0, "mid_rst.count"});
        tc_col = 0;
        tc_row = 0;
        repeat (4) @(posedge clk);
        #1 select = 1'b0;
        frames(60);
        status("after_rst", 1'b0, 0);
        probe("after_rst_card0", 60, 60, 1'b1, WHITE);
        probe("after_rst_card10", cx(10), cy(10), 1'b1, WHITE);
        probe("after_rst_border0", 22, 60, 1'b1, BLACK);
    endtask

    initial begin
        reset_n = 1'b0;
        de      = 1'b0;
        frame   = 1'b0;
        select  = 1'b0;
        move_x  = 1'b0;
        move_y  = 1'b0;
        sx      = 10'd0;
        sy      = 10'd0;
        test_reset();
        test_cursor();
        test_mismatch();
        test_match();
        test_win();
        test_reset_mid_reveal();
        repeat (3) @(posedge clk);
        #1 done = 1'b1;
    end
endmodule
